// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader.
package fifo_rd_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 32;
    localparam int unsigned USEDW_W    = 5;
    // Wide enough to hold FIFO_DEPTH itself.
    localparam int unsigned CNT_W      = 6;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t BURST = 2'd1;
    localparam state_t DRAIN = 2'd2;

    // The FIFO's word count wraps to 0 when full; the full flag restores the missing MSB.
    function automatic logic [CNT_W-1:0] eff_occ(input logic                full_n,
                                                 input logic [USEDW_W-1:0] use_dw);
        return full_n ? {1'b0, use_dw} : CNT_W'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_skid_buf.sv
// Two-entry data+last buffer that absorbs the FIFO's registered read latency.
// A byte arriving on din is presented straight to the output when the buffer is
// empty, so it can leave in the same cycle it arrives; otherwise it is stored.
module reader_skid_buf
    import fifo_rd_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              clear_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              last_in,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] dout,
    output logic              last_out,
    output logic              valid
);

    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              last0_q, last0_d, last1_q, last1_d;
    logic [1:0]        count_q, count_d;
    logic              bypass;

    assign bypass   = (count_q == 2'd0) && push;
    assign valid    = (count_q != 2'd0) || push;
    assign dout     = bypass ? din : data0_q;
    assign last_out = bypass ? last_in : last0_q;
    assign count    = count_q;

    // Occupancy follows count + push - pop; entry 0 is always the head.
    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        count_d = count_q;
        unique case (count_q)
            2'd0: begin
                if (push && !pop) begin
                    data0_d = din;
                    last0_d = last_in;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    data0_d = din;
                    last0_d = last_in;
                end else if (push) begin
                    data1_d = din;
                    last1_d = last_in;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    if (push) begin
                        data1_d = din;
                        last1_d = last_in;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    // Buffer storage with async reset and synchronous clear.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            count_q <= 2'd0;
        end else if (!clear_n) begin
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Consumer end of the 32x8 FIFO: waits for BURST_LEN bytes, then drains a
// fixed-length burst onto a valid/ready byte stream.
// Optional macro BURST_TIMEOUT_EN: after TIMEOUT idle cycles with a partial
// fill, start a short burst that drains whatever is stored.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               CLEAR_N,
    input  logic               F_EMPTY_N,
    input  logic               F_FULL_N,
    input  logic [USEDW_W-1:0] USE_DW,
    input  logic [DATA_W-1:0]  FIFO_DATA,
    output logic               READ,
    output logic [DATA_W-1:0]  DOUT,
    output logic               DOUT_VALID,
    input  logic               DOUT_READY,
    output logic               DOUT_LAST,
    output logic               BURST_DONE
);

    localparam logic [CNT_W-1:0] BLEN_FULL = CNT_W'(BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > FIFO_DEPTH) begin : g_bad_burst_len
        $error("BURST_LEN must be within 1..FIFO_DEPTH");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] blen_q, blen_d;
    logic             inflight_q;
    logic             last_pend_q;
    logic [CNT_W-1:0] occ;
    logic             read_last;
    logic             pop;
    logic [1:0]       sb_count;
    logic             sb_last;
    logic             start_partial;

    assign occ = eff_occ(F_FULL_N, USE_DW);

    // Issue a read only while the buffer can still take every byte already requested.
    assign READ = (state_q == BURST) && F_EMPTY_N && (rd_cnt_q < blen_q) &&
                  (({1'b0, sb_count} + {2'b00, inflight_q}) < 3'd2);

    assign read_last  = READ && ((rd_cnt_q + CNT_W'(1)) == blen_q);
    assign pop        = DOUT_VALID && DOUT_READY;
    assign DOUT_LAST  = DOUT_VALID && sb_last;
    assign BURST_DONE = (state_q == DRAIN) && (sb_count == 2'd0) && !inflight_q;

`ifdef BURST_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer_q;
    logic             timer_armed;

    assign timer_armed   = (state_q == IDLE) && F_EMPTY_N && (occ < BLEN_FULL) &&
                           (occ != '0);
    assign start_partial = timer_armed && (timer_q == TMR_W'(TIMEOUT - 1));

    // Idle timer: counts qualifying cycles, restarts whenever a condition drops.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            timer_q <= '0;
        end else if (!CLEAR_N || !timer_armed) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end
`else
    assign start_partial = 1'b0;
`endif

    // Burst sequencing: IDLE -> BURST -> DRAIN -> IDLE.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        blen_d   = blen_q;
        unique case (state_q)
            IDLE: begin
                if (occ >= BLEN_FULL) begin
                    state_d = BURST;
                    blen_d  = BLEN_FULL;
                end else if (start_partial) begin
                    state_d = BURST;
                    blen_d  = occ;
                end
            end
            BURST: begin
                if (READ) begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
                if (read_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (BURST_DONE) begin
                    state_d  = IDLE;
                    rd_cnt_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                rd_cnt_d = '0;
            end
        endcase
    end

    // Control state; clear also forgets any read still in flight.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            blen_q      <= '0;
            inflight_q  <= 1'b0;
            last_pend_q <= 1'b0;
        end else if (!CLEAR_N) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            blen_q      <= '0;
            inflight_q  <= 1'b0;
            last_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            blen_q      <= blen_d;
            inflight_q  <= READ;
            last_pend_q <= read_last;
        end
    end

    reader_skid_buf u_skid (
        .CLOCK    (CLOCK),
        .RESET_N  (RESET_N),
        .clear_n  (CLEAR_N),
        .push     (inflight_q),
        .din      (FIFO_DATA),
        .last_in  (last_pend_q),
        .pop      (pop),
        .count    (sb_count),
        .dout     (DOUT),
        .last_out (sb_last),
        .valid    (DOUT_VALID)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader with a behavioural 32x8 FIFO and a byte scoreboard.
module tb_fifo_burst_reader;

    logic       CLOCK = 1'b0;
    logic       RESET_N, CLEAR_N, F_EMPTY_N, F_FULL_N;
    logic [4:0] USE_DW;
    logic [7:0] FIFO_DATA;
    logic       READ;
    logic [7:0] DOUT;
    logic       DOUT_VALID, DOUT_READY, DOUT_LAST, BURST_DONE;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem[$];
    logic [7:0] pend[$];
    logic [8:0] sb[$];   // {last, data}

    int   cyc = 0;
    int   read_n, first_read, last_read, xfer_n, first_xfer, last_xfer, done_n;
    logic exp_done = 1'b0;
    logic hold_chk = 1'b0;
    logic [8:0] hold_v;
    logic rd_s;

    always #5 CLOCK = ~CLOCK;

    fifo_burst_reader #(
        .BURST_LEN (8),
        .TIMEOUT   (64)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .CLEAR_N    (CLEAR_N),
        .F_EMPTY_N  (F_EMPTY_N),
        .F_FULL_N   (F_FULL_N),
        .USE_DW     (USE_DW),
        .FIFO_DATA  (FIFO_DATA),
        .READ       (READ),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .DOUT_LAST  (DOUT_LAST),
        .BURST_DONE (BURST_DONE)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void set_flags();
        int n;
        n = mem.size();
        F_EMPTY_N = (n != 0);
        F_FULL_N  = (n < 32);
        USE_DW    = n[4:0];
    endfunction

    // Queue a FIFO write (lands at the next edge) and its expected output.
    task automatic wr(input logic [7:0] d, input logic last);
        pend.push_back(d);
        sb.push_back({last, d});
    endtask

    task automatic reset_stats();
        read_n = 0; first_read = 0; last_read = 0;
        xfer_n = 0; first_xfer = 0; last_xfer = 0; done_n = 0;
    endtask

    // One clock: monitor at the falling edge, FIFO model and stimulus after the rising edge.
    task automatic tick();
        logic [8:0] e;
        @(negedge CLOCK);
        cyc++;
        chk("no_underflow_read", {31'b0, READ && !F_EMPTY_N}, 0);
        chk("burst_done", {31'b0, BURST_DONE}, {31'b0, exp_done});
        exp_done = 1'b0;
        if (BURST_DONE) done_n++;
        if (hold_chk) chk("hold_stable", {DOUT_VALID, DOUT_LAST, DOUT}, {1'b1, hold_v});
        hold_chk = DOUT_VALID && !DOUT_READY && CLEAR_N;
        hold_v   = {DOUT_LAST, DOUT};
        if (DOUT_VALID && DOUT_READY && CLEAR_N) begin
            chk("sb_has_entry", {31'b0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("dout_byte", {DOUT_LAST, DOUT}, e);
                exp_done = e[8];
            end
            if (xfer_n == 0) first_xfer = cyc;
            last_xfer = cyc;
            xfer_n++;
        end
        if (READ) begin
            if (read_n == 0) first_read = cyc;
            last_read = cyc;
            read_n++;
        end
        rd_s = READ;
        @(posedge CLOCK);
        #1;
        if (!RESET_N || !CLEAR_N) begin
            mem.delete();
            pend.delete();
        end else begin
            if (rd_s && mem.size() != 0) FIFO_DATA = mem.pop_front();
            while (pend.size() != 0) mem.push_back(pend.pop_front());
        end
        set_flags();
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while ((sb.size() != 0 || DOUT_VALID) && k < max) begin
            tick();
            k++;
        end
        chk("drain_in_time", {31'b0, k < max}, 1);
        tick();
        tick();
        tick();
    endtask

    task automatic wait_xfer(input int n, input int max);
        int k;
        k = 0;
        while (xfer_n < n && k < max) begin
            tick();
            k++;
        end
        chk("xfer_in_time", {31'b0, k < max}, 1);
    endtask

    initial begin
        RESET_N    = 1'b0;
        CLEAR_N    = 1'b1;
        DOUT_READY = 1'b0;
        FIFO_DATA  = 8'h00;
        set_flags();
        reset_stats();
        tick();
        tick();
        chk("rst_read", {31'b0, READ}, 0);
        chk("rst_dout", {24'b0, DOUT}, 0);
        chk("rst_valid", {31'b0, DOUT_VALID}, 0);
        chk("rst_last", {31'b0, DOUT_LAST}, 0);
        chk("rst_done", {31'b0, BURST_DONE}, 0);
        RESET_N = 1'b1;
        tick();

        // Full 8-byte burst with the sink always ready.
        reset_stats();
        DOUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i), i == 7);
        wait_idle(100);
        chk("t1_reads", read_n, 8);
        chk("t1_read_span", last_read - first_read, 7);
        chk("t1_xfers", xfer_n, 8);
        chk("t1_xfer_span", last_xfer - first_xfer, 7);
        chk("t1_latency", first_xfer - first_read, 1);
        chk("t1_done_n", done_n, 1);

        // Full FIFO: USE_DW wraps to 0, occupancy must come from F_FULL_N.
        reset_stats();
        for (int i = 0; i < 32; i++) wr(8'h40 + 8'(i), (i % 8) == 7);
        wait_idle(300);
        chk("t2_reads", read_n, 32);
        chk("t2_xfers", xfer_n, 32);
        chk("t2_done_n", done_n, 4);

        // Back-pressure for 5 cycles mid-burst.
        reset_stats();
        for (int i = 0; i < 8; i++) wr(8'h80 + 8'(i), i == 7);
        wait_xfer(3, 50);
        DOUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_valid_held", {31'b0, DOUT_VALID}, 1);
            if (i >= 1) chk("t3_read_stalled", {31'b0, READ}, 0);
        end
        DOUT_READY = 1'b1;
        wait_idle(100);
        chk("t3_reads", read_n, 8);
        chk("t3_xfers", xfer_n, 8);
        chk("t3_done_n", done_n, 1);

        // Below threshold: nothing moves until the 8th byte is written.
        reset_stats();
        for (int i = 0; i < 5; i++) wr(8'hA0 + 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_no_read", {31'b0, READ}, 0);
        end
        for (int i = 5; i < 8; i++) wr(8'hA0 + 8'(i), i == 7);
        wait_idle(100);
        chk("t4_reads", read_n, 8);
        chk("t4_xfers", xfer_n, 8);

        // Synchronous clear while the 3rd byte is on the output.
        reset_stats();
        for (int i = 0; i < 8; i++) wr(8'hC0 + 8'(i), i == 7);
        wait_xfer(2, 50);
        DOUT_READY = 1'b0;
        CLEAR_N    = 1'b0;
        sb.delete();
        tick();
        CLEAR_N = 1'b1;
        chk("t5_valid_cleared", {31'b0, DOUT_VALID}, 0);
        chk("t5_read_cleared", {31'b0, READ}, 0);
        chk("t5_last_cleared", {31'b0, DOUT_LAST}, 0);
        DOUT_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_no_stray_byte", {31'b0, DOUT_VALID}, 0);
        end
        chk("t5_xfers_before_clear", xfer_n, 2);

        // Normal operation after clear.
        reset_stats();
        for (int i = 0; i < 8; i++) wr(8'hD0 + 8'(i), i == 7);
        wait_idle(100);
        chk("t6_xfers", xfer_n, 8);
        chk("t6_done_n", done_n, 1);

`ifdef BURST_TIMEOUT_EN
        // Partial burst after the idle timeout.
        reset_stats();
        for (int i = 0; i < 3; i++) wr(8'hE0 + 8'(i), i == 2);
        for (int i = 0; i < 50; i++) tick();
        chk("t7_no_early_read", read_n, 0);
        wait_idle(200);
        chk("t7_xfers", xfer_n, 3);
        chk("t7_done_n", done_n, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Consumer end of the 32x8 synchronous FIFO. Monitors the FIFO's occupancy and empty/full flags, and drives its READ strobe.
- Once enough bytes are stored, it drains a fixed-length burst onto a downstream valid/ready byte stream.
- Absorbs the FIFO's 1-cycle registered read latency with a 2-entry skid buffer, so back-pressure never loses a byte.

Parameters:
- BURST_LEN, 8, bytes per burst (1..32).
- TIMEOUT, 64, idle cycles before a partial burst starts (used only with BURST_TIMEOUT_EN).

Ports:
- CLOCK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous reset, active-low.
- CLEAR_N  in  1  synchronous clear, active-low; same semantics as the FIFO's clear.
- F_EMPTY_N  in  1  FIFO not-empty flag.
- F_FULL_N  in  1  FIFO not-full flag.
- USE_DW  in  5  FIFO occupancy; reads 0 when the FIFO is full.
- FIFO_DATA  in  8  FIFO read data, valid 1 cycle after READ.
- READ  out  1  FIFO read strobe.
- DOUT  out  8  downstream data.
- DOUT_VALID  out  1  DOUT holds a valid byte.
- DOUT_READY  in  1  downstream accepts the byte.
- DOUT_LAST  out  1  qualifies the final byte of a burst.
- BURST_DONE  out  1  1-cycle pulse when a burst has fully left the block.

Behaviour:
- Reset (RESET_N=0) values: READ=0, DOUT=0, DOUT_VALID=0, DOUT_LAST=0, BURST_DONE=0; state IDLE; all counters 0; skid buffer empty.
- CLEAR_N=0 at a clock edge gives the same result as reset, synchronously. Any in-flight read is discarded: no capture on the following cycle.
- Effective occupancy: occ = 32 when F_FULL_N=0, otherwise USE_DW.
- State IDLE:
  - Goes to BURST when occ >= BURST_LEN.
  - Burst length register blen is loaded with BURST_LEN.
- State BURST:
  - READ=1 when F_EMPTY_N=1, rd_cnt < blen, and (skid entries + in-flight) < 2.
  - Each READ increments rd_cnt.
  - When rd_cnt reaches blen, go to DRAIN.
- State DRAIN:
  - Waits until the skid buffer is empty and no read is in flight.
  - Then pulses BURST_DONE for 1 cycle, clears rd_cnt, and returns to IDLE.
- READ is combinational from registered state and input flags.
- READ is never asserted when F_EMPTY_N=0, so the FIFO's underflow assertion must never fire.
- Read latency: a READ in cycle N captures FIFO_DATA into the skid buffer at edge N+1.
  - If the buffer is empty, DOUT_VALID is high in cycle N+1.
  - Minimum latency from READ to DOUT_VALID is therefore 1 cycle.
- Handshake:
  - A byte transfers when DOUT_VALID and DOUT_READY are both 1.
  - DOUT, DOUT_VALID and DOUT_LAST stay stable while DOUT_VALID=1 and DOUT_READY=0.
- Throughput: 1 byte/cycle sustained while DOUT_READY=1 and the FIFO is non-empty.
- DOUT_LAST is tagged onto the byte fetched by the blen-th READ of the burst, and travels with that byte through the skid buffer.
- Capture and pop in the same cycle are allowed; the skid buffer's occupancy is unchanged in that case.
- If the FIFO goes empty mid-burst (the writer stalled), READ deasserts. The block stays in BURST and resumes when F_EMPTY_N returns to 1; there is no partial-burst termination.
- Counters: rd_cnt is 6 bits, so that a value of 32 is representable.

Optional Feature:
- Macro: BURST_TIMEOUT_EN.
- Defined:
  - A timer counts cycles in IDLE with F_EMPTY_N=1 and occ < BURST_LEN; it resets when either condition fails.
  - At TIMEOUT, go to BURST with blen = occ, so a partial burst drains all residual bytes. DOUT_LAST and BURST_DONE behave as for a full burst.
- Undefined:
  - No timer logic is built.
  - Bytes below the threshold wait in the FIFO indefinitely.

Decomposition:
- Package fifo_rd_pkg holds:
  - state enum {IDLE, BURST, DRAIN}, 2 bits;
  - constants DATA_W=8, FIFO_DEPTH=32, USEDW_W=5.
- Sub-module reader_skid_buf, the 2-entry data+last buffer:
  - inputs: push, din, last_in, pop (valid&ready);
  - outputs: count[1:0], dout, last_out, valid.

Test Plan:
- Preload FIFO with 8 bytes 0x10..0x17, BURST_LEN=8, DOUT_READY=1 -> 8 consecutive READ cycles; DOUT carries 0x10..0x17 on consecutive cycles; DOUT_LAST on 0x17; BURST_DONE 1 cycle after the last transfer.
- FIFO full (USE_DW=0, F_FULL_N=0), BURST_LEN=32 -> burst starts; 32 bytes out; DOUT_LAST on the 32nd byte.
- DOUT_READY low for 5 cycles mid-burst -> READ stops after skid entries + in-flight = 2; DOUT is held; no byte is lost or duplicated; stream resumes in order.
- FIFO holds 5 bytes with BURST_LEN=8, writer adds 3 bytes 10 cycles later -> no READ until occ=8, then a full 8-byte burst.
- CLEAR_N low during BURST at the 3rd byte -> next cycle: IDLE, DOUT_VALID=0, READ=0; the in-flight byte is dropped.
- With BURST_TIMEOUT_EN: 3 bytes, no further writes -> after 64 cycles a 3-byte burst; DOUT_LAST on the 3rd byte; BURST_DONE pulse.
